// File: rtl/apb_mbox_pkg.sv
// Shared types and constants for the mailbox APB requester.
// Mailbox data is at most MBOX_DATA_W bits wide; the response record is sized to it.
package apb_mbox_pkg;

    localparam int unsigned MBOX_DATA_W = 32;
    localparam int unsigned PSLVERR_W   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    typedef struct packed {
        logic [MBOX_DATA_W-1:0] rdata;
        logic                   err;
        logic                   timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_mbox_master.sv
// APB3 requester: turns one valid/ready command into a SETUP/ACCESS transfer
// and returns data/status on a valid/ready response port. One transfer in flight.
module apb_mbox_master
    import apb_mbox_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = MBOX_DATA_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 pclk,
    input  logic                 preset,

    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  logic [DATA_W-1:0]    cmd_wdata,

    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic                 rsp_err,
    output logic                 rsp_timeout,

    output logic                 psel,
    output logic                 penable,
    output logic                 pwrite,
    output logic [ADDR_W-1:0]    paddr,
    output logic [DATA_W-1:0]    pwdata,
    input  logic                 pready,
    input  logic [DATA_W-1:0]    prdata,
    input  logic [PSLVERR_W-1:0] pslverr
);

    // TIMEOUT == 0 disables the counter; keep at least one bit so the vector is legal.
    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    apb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    apb_rsp_t          rsp_q, rsp_d;
    logic              timed_out;

    assign timed_out = (TIMEOUT != 0) && !pready && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_d       = rsp_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // pready is checked first so it beats a coincident timeout.
                if (pready) begin
                    rsp_d.rdata   = pwrite_q ? '0 : MBOX_DATA_W'(prdata);
                    rsp_d.err     = |pslverr;
                    rsp_d.timeout = 1'b0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (timed_out) begin
                    rsp_d.rdata   = '0;
                    rsp_d.err     = 1'b1;
                    rsp_d.timeout = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_q.rdata[DATA_W-1:0];
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_mbox_master.sv
// Directed bench for apb_mbox_master against a small mailbox memory slave
// whose pready/pslverr can be forced from the stimulus.
module tb_apb_mbox_master;

    logic        pclk = 1'b0;
    logic        preset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata = '0;
    logic [1:0]  pslverr;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] rd, held;
    logic        er, to;
    int          lat;

    logic [31:0] mem [64];

    apb_mbox_master #(
        .ADDR_W  (12),
        .DATA_W  (32),
        .TIMEOUT (16)
    ) dut (
        .pclk        (pclk),
        .preset      (preset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pready      (pready),
        .prdata      (prdata),
        .pslverr     (pslverr)
    );

    always #5 pclk = ~pclk;

    // Mailbox slave: read data registered during SETUP, write committed on the ready beat.
    always @(posedge pclk) begin
        if (psel && !penable && !pwrite) prdata <= mem[paddr[7:2]];
        if (psel && penable && pready && pwrite) mem[paddr[7:2]] <= pwdata;
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one command with rsp_ready=1; returns response and cycles from SETUP to rsp_valid.
    task automatic run_xfer(input logic w, input logic [11:0] a, input logic [31:0] d,
                            output logic [31:0] r, output logic e, output logic t,
                            output int l);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        l = 0;
        while (!rsp_valid && l < 100) begin
            tick();
            l++;
        end
        r = rsp_rdata;
        e = rsp_err;
        t = rsp_timeout;
        tick();
    endtask

    initial begin
        preset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        pready    = 1'b1;
        pslverr   = 2'b00;
        tick();
        tick();

        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_paddr", paddr, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        preset = 1'b0;
        tick();

        // 1: write then read back
        run_xfer(1'b1, 12'h010, 32'hDEADBEEF, rd, er, to, lat);
        check("wr_rdata_zero", rd, 0);
        check("wr_err", er, 0);
        check("wr_lat", lat, 2);
        run_xfer(1'b0, 12'h010, 32'h0, rd, er, to, lat);
        check("rd_data", rd, 32'hDEADBEEF);
        check("rd_err", er, 0);
        check("rd_timeout", to, 0);

        // 2: cycle-accurate zero-wait read
        check("c0_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 12'h010;
        rsp_ready = 1'b0;
        tick();
        cmd_valid = 1'b0;
        check("c1_psel", psel, 1);
        check("c1_penable", penable, 0);
        check("c1_paddr", paddr, 12'h010);
        check("c1_cmd_ready", cmd_ready, 0);
        tick();
        check("c2_psel", psel, 1);
        check("c2_penable", penable, 1);
        check("c2_paddr", paddr, 12'h010);
        check("c2_rsp_valid", rsp_valid, 0);
        tick();
        check("c3_rsp_valid", rsp_valid, 1);
        check("c3_psel", psel, 0);
        check("c3_rdata", rsp_rdata, 32'hDEADBEEF);

        // 3: response back-pressure; a new command waits meanwhile
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 12'h020;
        cmd_wdata = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rdata", rsp_rdata, 32'hDEADBEEF);
            check("bp_err", rsp_err, 0);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_psel", psel, 0);
        end
        rsp_ready = 1'b1;
        tick();
        check("hs_rsp_valid", rsp_valid, 0);
        check("hs_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        check("nx_psel", psel, 1);
        check("nx_paddr", paddr, 12'h020);
        check("nx_pwrite", pwrite, 1);
        check("nx_pwdata", pwdata, 32'h12345678);
        tick();
        tick();
        check("nx_rsp_valid", rsp_valid, 1);
        check("nx_rdata", rsp_rdata, 0);
        tick();
        run_xfer(1'b0, 12'h020, 32'h0, rd, er, to, lat);
        check("nx_readback", rd, 32'h12345678);

        // 4a: slave never ready -> timeout after 16 ACCESS cycles
        pready = 1'b0;
        run_xfer(1'b0, 12'h010, 32'h0, rd, er, to, lat);
        check("to_lat", lat, 17);
        check("to_rdata", rd, 0);
        check("to_err", er, 1);
        check("to_flag", to, 1);
        check("to_cmd_ready", cmd_ready, 1);

        // 4b: pready arrives on the 16th ACCESS cycle and wins
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 12'h010;
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) tick();
        check("lt_penable", penable, 1);
        check("lt_rsp_valid", rsp_valid, 0);
        pready = 1'b1;
        tick();
        check("lt_rsp_valid1", rsp_valid, 1);
        check("lt_rdata", rsp_rdata, 32'hDEADBEEF);
        check("lt_err", rsp_err, 0);
        check("lt_timeout", rsp_timeout, 0);
        tick();

        // 5: slave error
        pslverr = 2'b10;
        run_xfer(1'b0, 12'h010, 32'h0, rd, er, to, lat);
        check("se_err", er, 1);
        check("se_timeout", to, 0);
        check("se_rdata", rd, 32'hDEADBEEF);
        pslverr = 2'b00;

        // 6: reset during ACCESS
        pready    = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 12'h010;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("ra_penable", penable, 1);
        #2 preset = 1'b1;
        #1;
        check("ra_psel", psel, 0);
        check("ra_penable0", penable, 0);
        check("ra_cmd_ready", cmd_ready, 1);
        preset = 1'b0;
        pready = 1'b1;
        tick();
        check("ra_rsp_valid", rsp_valid, 0);
        check("ra_psel_idle", psel, 0);
        run_xfer(1'b0, 12'h010, 32'h0, rd, er, to, lat);
        check("ra_next_rdata", rd, 32'hDEADBEEF);
        check("ra_next_err", er, 0);
        check("ra_next_lat", lat, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
